// File: rtl/game_stage_controller_if.sv
// Purpose: signal bundle between the game-flow sequencer and the stage-dependent world
//          (monsters, boss, player, key debouncer, frame timing).
// Latency: none, wires only. Backpressure: none, every signal is a level or a one-clk pulse.
// Ports:   master = controller side (consumes events, drives stage/score/lives/flags),
//          slave  = game-world side (drives events, observes controller outputs).
interface game_stage_controller_if #(
    parameter int SCORE_WIDTH = 16
);
    logic                   startOfFrame;
    logic                   start_key;
    logic                   all_monsters_dead;
    logic                   monster_died_pulse;
    logic                   boss_dead;
    logic                   player_hit;
    logic [2:0]             stage_num;
    logic                   monsters_enable;
    logic                   stage_resetN;
    logic [SCORE_WIDTH-1:0] score;
    logic [2:0]             lives;
    logic                   game_won;
    logic                   game_over;

    modport master (
        input  startOfFrame, start_key, all_monsters_dead, monster_died_pulse,
               boss_dead, player_hit,
        output stage_num, monsters_enable, stage_resetN, score, lives,
               game_won, game_over
    );

    modport slave (
        output startOfFrame, start_key, all_monsters_dead, monster_died_pulse,
               boss_dead, player_hit,
        input  stage_num, monsters_enable, stage_resetN, score, lives,
               game_won, game_over
    );
endinterface

// File: rtl/game_stage_controller.sv
// Purpose: game-flow sequencer (lobby/intro/play/clear/won/lost) with score and lives keeping.
// Latency: all outputs registered, one clk after the causing input/edge.
// Backpressure: none; events are pulses/levels consumed every clk, ignored outside their state.
// Ports: clk, resetN (async active-low), gs (game_stage_controller_if.master).
// Build option: GAME_BOSS_STAGE_EN -> stage 3 is a boss stage finished by boss_dead;
//               undefined -> stage 3 is skipped (2 -> 4) and boss_dead is ignored.
module game_stage_controller #(
    parameter int INTRO_FRAMES   = 60,
    parameter int CLEAR_FRAMES   = 90,
    parameter int LAST_STAGE     = 4,
    parameter int LIVES          = 3,
    parameter int MONSTER_POINTS = 10,
    parameter int SCORE_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     resetN,
    game_stage_controller_if.master  gs
);

    localparam int MAX_FRAMES = (INTRO_FRAMES > CLEAR_FRAMES) ? INTRO_FRAMES : CLEAR_FRAMES;
    localparam int FCW        = $clog2(MAX_FRAMES + 1);

    localparam logic [FCW-1:0] INTRO_LAST = FCW'(INTRO_FRAMES - 1);
    localparam logic [FCW-1:0] CLEAR_LAST = FCW'(CLEAR_FRAMES - 1);
    localparam logic [2:0]     LAST_STG   = 3'(LAST_STAGE);
    localparam logic [2:0]     LIVES_INIT = 3'(LIVES);

    typedef enum logic [2:0] {
        IDLE,
        INTRO,
        PLAY,
        CLEAR,
        WON,
        LOST
    } state_t;

    state_t                 state;
    logic [FCW-1:0]         frame_cnt;
    logic                   start_q;
    logic                   start_edge;
    logic                   stage_done;
    logic [2:0]             next_stage;
    logic [SCORE_WIDTH:0]   score_sum;
    logic [SCORE_WIDTH-1:0] score_sat;

    // A held key produces a single event: only the 0->1 transition counts.
    assign start_edge = gs.start_key & ~start_q;

    // Extra top bit catches the carry so the score sticks at all-ones.
    assign score_sum = {1'b0, gs.score} + (SCORE_WIDTH+1)'(MONSTER_POINTS);
    assign score_sat = score_sum[SCORE_WIDTH] ? '1 : score_sum[SCORE_WIDTH-1:0];

`ifdef GAME_BOSS_STAGE_EN
    // Stage 3 has no monsters; the boss decides when it is over.
    assign stage_done = (gs.stage_num == 3'd3) ? gs.boss_dead : gs.all_monsters_dead;
    assign next_stage = gs.stage_num + 3'd1;
`else
    logic unused_boss_dead;
    assign unused_boss_dead = gs.boss_dead;
    assign stage_done       = gs.all_monsters_dead;
    // The boss stage does not exist in this build, so stage 2 jumps straight to 4.
    assign next_stage       = ((gs.stage_num == 3'd2) && (LAST_STAGE > 3)) ? 3'd4
                                                                           : gs.stage_num + 3'd1;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state              <= IDLE;
            frame_cnt          <= '0;
            start_q            <= 1'b0;
            gs.stage_num       <= 3'd0;
            gs.monsters_enable <= 1'b0;
            gs.stage_resetN    <= 1'b1;
            gs.score           <= '0;
            gs.lives           <= LIVES_INIT;
            gs.game_won        <= 1'b0;
            gs.game_over       <= 1'b0;
        end else begin
            start_q         <= gs.start_key;
            // Default high; pulled low only on the edge that enters INTRO, so the
            // stage objects see the reset together with the new stage_num.
            gs.stage_resetN <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state           <= INTRO;
                        frame_cnt       <= '0;
                        gs.stage_num    <= 3'd1;
                        gs.score        <= '0;
                        gs.lives        <= LIVES_INIT;
                        gs.stage_resetN <= 1'b0;
                    end
                end

                INTRO: begin
                    if (gs.startOfFrame) begin
                        if (frame_cnt == INTRO_LAST) begin
                            state              <= PLAY;
                            frame_cnt          <= '0;
                            gs.monsters_enable <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                PLAY: begin
                    // Kills score even on the clk the stage ends or the player dies.
                    if (gs.monster_died_pulse) begin
                        gs.score <= score_sat;
                    end
                    if (gs.player_hit) begin
                        gs.lives <= gs.lives - 3'd1;
                    end
                    // Losing the last life wins over finishing the stage.
                    if (gs.player_hit && (gs.lives == 3'd1)) begin
                        state              <= LOST;
                        frame_cnt          <= '0;
                        gs.monsters_enable <= 1'b0;
                        gs.game_over       <= 1'b1;
                    end else if (stage_done) begin
                        state              <= CLEAR;
                        frame_cnt          <= '0;
                        gs.monsters_enable <= 1'b0;
                    end
                end

                CLEAR: begin
                    if (gs.startOfFrame) begin
                        if (frame_cnt == CLEAR_LAST) begin
                            frame_cnt <= '0;
                            if (gs.stage_num == LAST_STG) begin
                                state       <= WON;
                                gs.game_won <= 1'b1;
                            end else begin
                                state           <= INTRO;
                                gs.stage_num    <= next_stage;
                                gs.stage_resetN <= 1'b0;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                WON, LOST: begin
                    if (start_edge) begin
                        state        <= IDLE;
                        frame_cnt    <= '0;
                        gs.stage_num <= 3'd0;
                        gs.game_won  <= 1'b0;
                        gs.game_over <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    frame_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_stage_controller.sv
// Purpose: self-checking bench for game_stage_controller (directed scenarios + random games).
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: not applicable; stimulus is pulses and levels.
module tb_game_stage_controller;

    localparam int INTRO_F = 2;
    localparam int CLEAR_F = 3;
    localparam int LAST    = 4;
    localparam int NLIVES  = 3;
    localparam int PTS     = 10;
    localparam int SW      = 8;
`ifdef GAME_BOSS_STAGE_EN
    localparam bit BOSS = 1'b1;
`else
    localparam bit BOSS = 1'b0;
`endif

    logic clk    = 1'b0;
    logic resetN = 1'b0;

    game_stage_controller_if #(.SCORE_WIDTH(SW)) gif();

    game_stage_controller #(
        .INTRO_FRAMES(INTRO_F), .CLEAR_FRAMES(CLEAR_F), .LAST_STAGE(LAST),
        .LIVES(NLIVES), .MONSTER_POINTS(PTS), .SCORE_WIDTH(SW)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .gs(gif.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int stage_list[$];

    logic [SW-1:0] exp_score;
    logic [2:0]    exp_lives;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        gif.startOfFrame       = 1'b0;
        gif.start_key          = 1'b0;
        gif.all_monsters_dead  = 1'b0;
        gif.monster_died_pulse = 1'b0;
        gif.boss_dead          = 1'b0;
        gif.player_hit         = 1'b0;
    endtask

    task automatic sof_pulse();
        gif.startOfFrame = 1'b1;
        tick();
        gif.startOfFrame = 1'b0;
    endtask

    task automatic kill_pulse();
        gif.monster_died_pulse = 1'b1;
        tick();
        gif.monster_died_pulse = 1'b0;
    endtask

    task automatic amd_pulse();
        gif.all_monsters_dead = 1'b1;
        tick();
        gif.all_monsters_dead = 1'b0;
    endtask

    // Events the controller must ignore while not in PLAY/IDLE/end states.
    task automatic junk_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            gif.monster_died_pulse = 1'($urandom % 2);
            gif.player_hit         = 1'($urandom % 2);
            gif.start_key          = (($urandom % 4) == 0);
            tick();
            clear_inputs();
        end
    endtask

    function automatic logic [SW-1:0] add_points(input logic [SW-1:0] s);
        if (int'(s) + PTS > (1 << SW) - 1) return '1;
        return s + SW'(PTS);
    endfunction

    task automatic test_reset();
        clear_inputs();
        resetN = 1'b0;
        repeat (3) tick();
        total++; if (gif.stage_num !== 3'd0) begin bad++; $display("FAIL rst_stage got=%0d want=0", gif.stage_num); end
        total++; if (gif.monsters_enable !== 1'b0) begin bad++; $display("FAIL rst_men got=%0b want=0", gif.monsters_enable); end
        total++; if (gif.stage_resetN !== 1'b1) begin bad++; $display("FAIL rst_srn got=%0b want=1", gif.stage_resetN); end
        total++; if (gif.score !== '0) begin bad++; $display("FAIL rst_score got=%0d want=0", gif.score); end
        total++; if (gif.lives !== 3'(NLIVES)) begin bad++; $display("FAIL rst_lives got=%0d want=%0d", gif.lives, NLIVES); end
        total++; if (gif.game_won !== 1'b0) begin bad++; $display("FAIL rst_won got=%0b want=0", gif.game_won); end
        total++; if (gif.game_over !== 1'b0) begin bad++; $display("FAIL rst_over got=%0b want=0", gif.game_over); end
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_start_intro();
        gif.start_key = 1'b1;
        tick();
        total++; if (gif.stage_num !== 3'd1) begin bad++; $display("FAIL start_stage got=%0d want=1", gif.stage_num); end
        total++; if (gif.stage_resetN !== 1'b0) begin bad++; $display("FAIL start_srn_low got=%0b want=0", gif.stage_resetN); end
        total++; if (gif.monsters_enable !== 1'b0) begin bad++; $display("FAIL start_men got=%0b want=0", gif.monsters_enable); end
        tick();
        total++; if (gif.stage_resetN !== 1'b1) begin bad++; $display("FAIL start_srn_high got=%0b want=1", gif.stage_resetN); end
        // key still held through INTRO: must not count as another event
        kill_pulse();
        total++; if (gif.score !== '0) begin bad++; $display("FAIL intro_kill_ignored got=%0d want=0", gif.score); end
        sof_pulse();
        total++; if (gif.monsters_enable !== 1'b0) begin bad++; $display("FAIL intro_frame1 got=%0b want=0", gif.monsters_enable); end
        tick();
        sof_pulse();
        total++; if (gif.monsters_enable !== 1'b1) begin bad++; $display("FAIL intro_frame2 got=%0b want=1", gif.monsters_enable); end
        total++; if (gif.stage_num !== 3'd1) begin bad++; $display("FAIL play_stage got=%0d want=1", gif.stage_num); end
        gif.start_key = 1'b0;
        tick();
    endtask

    task automatic test_score();
        for (int i = 0; i < 3; i++) begin
            kill_pulse();
            tick();
        end
        total++; if (gif.score !== SW'(30)) begin bad++; $display("FAIL score_3kills got=%0d want=30", gif.score); end
    endtask

    task automatic test_stage_flow();
        amd_pulse();
        total++; if (gif.monsters_enable !== 1'b0) begin bad++; $display("FAIL clear_men got=%0b want=0", gif.monsters_enable); end
        kill_pulse();
        total++; if (gif.score !== SW'(30)) begin bad++; $display("FAIL clear_kill_ignored got=%0d want=30", gif.score); end
        repeat (CLEAR_F) sof_pulse();
        total++; if (gif.stage_num !== 3'd2) begin bad++; $display("FAIL next_stage2 got=%0d want=2", gif.stage_num); end
        total++; if (gif.stage_resetN !== 1'b0) begin bad++; $display("FAIL srn_stage2 got=%0b want=0", gif.stage_resetN); end
        repeat (INTRO_F) sof_pulse();
        amd_pulse();
        repeat (CLEAR_F) sof_pulse();
        total++; if (gif.stage_num !== (BOSS ? 3'd3 : 3'd4)) begin bad++; $display("FAIL after_stage2 got=%0d want=%0d", gif.stage_num, BOSS ? 3 : 4); end
        repeat (INTRO_F) sof_pulse();
`ifdef GAME_BOSS_STAGE_EN
        gif.all_monsters_dead = 1'b1;
        tick();
        tick();
        gif.all_monsters_dead = 1'b0;
        total++; if (gif.monsters_enable !== 1'b1) begin bad++; $display("FAIL boss_amd_ignored got=%0b want=1", gif.monsters_enable); end
        gif.boss_dead = 1'b1;
        tick();
        gif.boss_dead = 1'b0;
        total++; if (gif.monsters_enable !== 1'b0) begin bad++; $display("FAIL boss_done got=%0b want=0", gif.monsters_enable); end
        repeat (CLEAR_F) sof_pulse();
        total++; if (gif.stage_num !== 3'd4) begin bad++; $display("FAIL after_boss got=%0d want=4", gif.stage_num); end
        repeat (INTRO_F) sof_pulse();
`else
        gif.boss_dead = 1'b1;
        tick();
        tick();
        gif.boss_dead = 1'b0;
        total++; if (gif.monsters_enable !== 1'b1) begin bad++; $display("FAIL boss_ignored got=%0b want=1", gif.monsters_enable); end
`endif
        amd_pulse();
        repeat (CLEAR_F) sof_pulse();
        total++; if (gif.game_won !== 1'b1) begin bad++; $display("FAIL won_flag got=%0b want=1", gif.game_won); end
        repeat (2) sof_pulse();
        total++; if (gif.game_won !== 1'b1) begin bad++; $display("FAIL won_held got=%0b want=1", gif.game_won); end
        gif.start_key = 1'b1;
        tick();
        gif.start_key = 1'b0;
        total++; if (gif.stage_num !== 3'd0) begin bad++; $display("FAIL won_to_idle_stage got=%0d want=0", gif.stage_num); end
        total++; if (gif.game_won !== 1'b0) begin bad++; $display("FAIL won_cleared got=%0b want=0", gif.game_won); end
        tick();
    endtask

    task automatic test_lives();
        gif.start_key = 1'b1;
        tick();
        gif.start_key = 1'b0;
        total++; if (gif.score !== '0) begin bad++; $display("FAIL newgame_score got=%0d want=0", gif.score); end
        total++; if (gif.lives !== 3'(NLIVES)) begin bad++; $display("FAIL newgame_lives got=%0d want=%0d", gif.lives, NLIVES); end
        repeat (INTRO_F) sof_pulse();
        gif.player_hit = 1'b1;
        tick();
        gif.player_hit = 1'b0;
        total++; if (gif.lives !== 3'(NLIVES - 1)) begin bad++; $display("FAIL hit_lives got=%0d want=%0d", gif.lives, NLIVES - 1); end
        gif.player_hit = 1'b1;
        gif.all_monsters_dead = 1'b1;
        tick();
        clear_inputs();
        total++; if (gif.lives !== 3'(NLIVES - 2)) begin bad++; $display("FAIL hit_done_lives got=%0d want=%0d", gif.lives, NLIVES - 2); end
        total++; if (gif.monsters_enable !== 1'b0) begin bad++; $display("FAIL hit_done_clear got=%0b want=0", gif.monsters_enable); end
        repeat (CLEAR_F) sof_pulse();
        repeat (INTRO_F) sof_pulse();
        gif.player_hit = 1'b1;
        gif.all_monsters_dead = 1'b1;
        gif.monster_died_pulse = 1'b1;
        tick();
        clear_inputs();
        total++; if (gif.game_over !== 1'b1) begin bad++; $display("FAIL lost_flag got=%0b want=1", gif.game_over); end
        total++; if (gif.lives !== 3'd0) begin bad++; $display("FAIL lost_lives got=%0d want=0", gif.lives); end
        total++; if (gif.score !== SW'(PTS)) begin bad++; $display("FAIL lost_kill_scores got=%0d want=%0d", gif.score, PTS); end
        repeat (CLEAR_F + 1) sof_pulse();
        total++; if (gif.stage_num !== 3'd2) begin bad++; $display("FAIL lost_stays got=%0d want=2", gif.stage_num); end
        total++; if (gif.game_won !== 1'b0) begin bad++; $display("FAIL lost_not_won got=%0b want=0", gif.game_won); end
        gif.start_key = 1'b1;
        tick();
        gif.start_key = 1'b0;
        total++; if (gif.game_over !== 1'b0) begin bad++; $display("FAIL lost_to_idle got=%0b want=0", gif.game_over); end
        tick();
    endtask

    task automatic test_reset_mid_play();
        gif.start_key = 1'b1;
        tick();
        gif.start_key = 1'b0;
        repeat (INTRO_F) sof_pulse();
        kill_pulse();
        gif.player_hit = 1'b1;
        tick();
        gif.player_hit = 1'b0;
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        total++; if (gif.stage_num !== 3'd0) begin bad++; $display("FAIL midrst_stage got=%0d want=0", gif.stage_num); end
        total++; if (gif.monsters_enable !== 1'b0) begin bad++; $display("FAIL midrst_men got=%0b want=0", gif.monsters_enable); end
        total++; if (gif.score !== '0) begin bad++; $display("FAIL midrst_score got=%0d want=0", gif.score); end
        total++; if (gif.lives !== 3'(NLIVES)) begin bad++; $display("FAIL midrst_lives got=%0d want=%0d", gif.lives, NLIVES); end
        repeat (2) tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_random_games(input int n_games);
        bit lost;
        int s;
        for (int g = 0; g < n_games; g++) begin
            exp_score = '0;
            exp_lives = 3'(NLIVES);
            lost = 1'b0;
            gif.start_key = 1'b1;
            tick();
            gif.start_key = 1'b0;
            total++; if (gif.stage_num !== 3'd1) begin bad++; $display("FAIL rnd_start g=%0d got=%0d want=1", g, gif.stage_num); end
            total++; if (gif.lives !== exp_lives) begin bad++; $display("FAIL rnd_start_lives g=%0d got=%0d want=%0d", g, gif.lives, exp_lives); end
            for (int idx = 0; idx < stage_list.size() && !lost; idx++) begin
                s = stage_list[idx];
                for (int f = 0; f < INTRO_F; f++) begin
                    junk_cycles(int'($urandom_range(0, 3)));
                    sof_pulse();
                end
                total++; if (gif.monsters_enable !== 1'b1 || gif.stage_num !== 3'(s)) begin bad++; $display("FAIL rnd_play g=%0d men=%0b stage=%0d want stage=%0d", g, gif.monsters_enable, gif.stage_num, s); end
                total++; if (gif.score !== exp_score) begin bad++; $display("FAIL rnd_intro_score g=%0d got=%0d want=%0d", g, gif.score, exp_score); end
                for (int e = 0; e < int'($urandom_range(4, 14)) && !lost; e++) begin
                    gif.monster_died_pulse = (($urandom % 8) < 5);
                    gif.player_hit         = (($urandom % 16) == 0);
                    gif.startOfFrame       = 1'($urandom % 2);
                    if (gif.monster_died_pulse) exp_score = add_points(exp_score);
                    if (gif.player_hit) begin
                        exp_lives = exp_lives - 3'd1;
                        if (exp_lives == 3'd0) lost = 1'b1;
                    end
                    tick();
                    clear_inputs();
                    total++; if (gif.score !== exp_score || gif.lives !== exp_lives) begin bad++; $display("FAIL rnd_evt g=%0d score=%0d lives=%0d want %0d/%0d", g, gif.score, gif.lives, exp_score, exp_lives); end
                end
                if (lost) begin
                    total++; if (gif.game_over !== 1'b1 || gif.monsters_enable !== 1'b0) begin bad++; $display("FAIL rnd_lost g=%0d over=%0b men=%0b want 1/0", g, gif.game_over, gif.monsters_enable); end
                end else begin
                    gif.monster_died_pulse = 1'($urandom % 2);
                    gif.player_hit         = (exp_lives > 3'd1) && (($urandom % 3) == 0);
                    if (BOSS && s == 3) gif.boss_dead = 1'b1;
                    else                gif.all_monsters_dead = 1'b1;
                    if (gif.monster_died_pulse) exp_score = add_points(exp_score);
                    if (gif.player_hit) exp_lives = exp_lives - 3'd1;
                    tick();
                    clear_inputs();
                    total++; if (gif.monsters_enable !== 1'b0 || gif.score !== exp_score || gif.lives !== exp_lives) begin bad++; $display("FAIL rnd_done g=%0d men=%0b score=%0d lives=%0d want 0/%0d/%0d", g, gif.monsters_enable, gif.score, gif.lives, exp_score, exp_lives); end
                    for (int f = 0; f < CLEAR_F; f++) begin
                        junk_cycles(int'($urandom_range(0, 3)));
                        sof_pulse();
                    end
                    if (idx == stage_list.size() - 1) begin
                        total++; if (gif.game_won !== 1'b1) begin bad++; $display("FAIL rnd_won g=%0d got=%0b want=1", g, gif.game_won); end
                    end else begin
                        total++; if (gif.stage_num !== 3'(stage_list[idx + 1]) || gif.stage_resetN !== 1'b0) begin bad++; $display("FAIL rnd_next g=%0d stage=%0d srn=%0b want %0d/0", g, gif.stage_num, gif.stage_resetN, stage_list[idx + 1]); end
                    end
                    total++; if (gif.score !== exp_score) begin bad++; $display("FAIL rnd_clear_score g=%0d got=%0d want=%0d", g, gif.score, exp_score); end
                end
            end
            tick();
            gif.start_key = 1'b1;
            tick();
            gif.start_key = 1'b0;
            total++; if (gif.stage_num !== 3'd0 || gif.game_won !== 1'b0 || gif.game_over !== 1'b0) begin bad++; $display("FAIL rnd_idle g=%0d stage=%0d won=%0b over=%0b want 0/0/0", g, gif.stage_num, gif.game_won, gif.game_over); end
            tick();
        end
    endtask

    initial begin
        // Stage order from the game rules: 1..LAST, stage 3 only when the boss stage exists.
        for (int st = 1; st <= LAST; st++) begin
            if (st != 3 || BOSS || LAST <= 3) stage_list.push_back(st);
        end
        test_reset();
        test_start_intro();
        test_score();
        test_stage_flow();
        test_lives();
        test_reset_mid_play();
        test_random_games(6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
